dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache sitting between the pipeline MEM stage and the
//  256-bit line data memory. It is the initiator side of the memory enable/write/ack handshake.
//  It serves 32-bit CPU loads and stores, stalls the pipeline on a miss, writes back dirty victims
//  and refills whole 32-byte lines.
// PARAMETERS
//  LINES       16   number of cache lines; power of 2, 2..64
//  IDX_W       4    log2(LINES); index = addr[IDX_W+4:5], tag = addr[31:IDX_W+5], word = addr[4:2]
// PORTS
//  clk_i          in   1    clock, all state updates on posedge
//  rst_i          in   1    asynchronous reset, active-high
//  p1_addr_i      in   32   CPU byte address; word-aligned, addr[1:0] ignored
//  p1_data_i      in   32   CPU store data
//  p1_MemRead_i   in   1    load request, held by CPU while p1_stall_o=1
//  p1_MemWrite_i  in   1    store request, held by CPU while p1_stall_o=1
//  p1_data_o      out  32   load data, valid when read request and p1_stall_o=0
//  p1_stall_o     out  1    freeze pipeline
//  mem_enable_o   out  1    memory request, held until mem_ack_i
//  mem_write_o    out  1    1=line write, 0=line read
//  mem_addr_o     out  32   line address, bits[4:0]=0
//  mem_data_o     out  256  write-back line data
//  mem_data_i     in   256  refill data, valid the cycle AFTER mem_ack_i
//  mem_ack_i      in   1    one-cycle completion pulse from memory
// BEHAVIOUR
//  - Storage: per line valid, dirty, tag, 256-bit data. Reset clears all valid and dirty bits; data and
//    tags are undefined. Output reset values: mem_enable_o=0, mem_write_o=0, mem_addr_o=0,
//    mem_data_o=0, p1_stall_o=0, p1_data_o=0.
//  - hit = req & valid[idx] & (tag[idx]==addr tag); req = MemRead|MemWrite. Both high: store wins.
//  - Load hit: p1_data_o = word addr[4:2] of the line, combinational, zero stall.
//  - Store hit: the word is written at posedge; dirty=1; zero stall.
//  - p1_stall_o = req & ~hit in IDLE, and 1 in every non-IDLE state; combinational.
//  - FSM states: IDLE, WRITEBACK, GAP, FETCH, REFILL.
//    IDLE: if req & ~hit, go to WRITEBACK if victim valid&dirty, else go to FETCH.
//    WRITEBACK: enable=1, write=1, addr={victim tag,idx,5'b0}, data=victim line. On ack, go to GAP.
//    GAP: enable=0 for exactly one cycle so that the memory returns to idle. Then go to FETCH.
//    FETCH: enable=1, write=0, addr={req tag,idx,5'b0}. On ack, go to REFILL.
//    REFILL: enable=0. Capture mem_data_i into the line; tag=req tag, valid=1, dirty=0. Then go to IDLE.
//    Back in IDLE the held request hits; a pending store merges its word and sets dirty then.
//  - All mem_* outputs are registered and stable for the whole transaction. enable drops on the edge
//    where ack is seen, and is never high in the cycle after ack.
//  - Miss latency = mem latency + 2 cycles (clean) or 2*mem latency + 3 cycles (dirty). With the
//    8-cycle memory: clean miss = 10 stall cycles, dirty miss = 19.
//  - mem_ack_i outside WRITEBACK/FETCH is ignored. Request changes during stall are a CPU protocol
//    violation and are not checked.
//  - Reset mid-transaction: FSM returns to IDLE at once. All lines become invalid and any in-flight
//    write-back is lost. The environment resets the memory at the same time.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0]. Both reset to 0.
//    hit_cnt_o increments once per request accepted in IDLE with hit, excluding the post-refill
//    re-hit. miss_cnt_o increments once per IDLE->WRITEBACK/FETCH transition. Both wrap at 2^32.
//  DCACHE_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1 reset, load 0x0000_0040 -> stall 10 cycles, one FETCH addr 0x40 write=0, p1_data_o = mem word 0.
//  2 load 0x44 right after case 1 -> hit, stall=0 same cycle, data = mem word 1, no mem_enable_o.
//  3 store 0xDEADBEEF @0x48, then load 0x48 -> both hit, load returns 0xDEADBEEF, dirty[2]=1.
//  4 load 0x0000_0248 (same idx 2, new tag) -> WRITEBACK addr 0x40 with the line holding 0xDEADBEEF
//    in word 2, 1 GAP cycle with enable=0, FETCH addr 0x240, 19 stall cycles total.
//  5 assert rst_i during FETCH of case 4 -> enable=0 and stall=0 immediately; load 0x44 then misses.
//  6 DCACHE_STATS_EN on, run cases 1-4 -> hit_cnt_o=3, miss_cnt_o=2.

Source files
------------

// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache between the pipeline
//   MEM stage and a 256-bit line memory. Loads and stores that hit complete
//   with no stall; a miss freezes the pipeline, writes back a dirty victim,
//   refills the whole 32-byte line and then lets the held request hit.
//
// Ports
//   clk_i, rst_i        clock and asynchronous active-high reset
//   p1_addr_i           CPU byte address (bits [1:0] ignored)
//   p1_data_i           CPU store data
//   p1_MemRead_i        load request, held while p1_stall_o is high
//   p1_MemWrite_i       store request, held while p1_stall_o is high (wins over load)
//   p1_data_o           load data, valid on a load with p1_stall_o low
//   p1_stall_o          pipeline freeze
//   mem_enable_o        memory request, held until mem_ack_i
//   mem_write_o         1 = line write-back, 0 = line fetch
//   mem_addr_o          line address, bits [4:0] always zero
//   mem_data_o          write-back line data
//   mem_data_i          refill data, valid the cycle after mem_ack_i
//   mem_ack_i           one-cycle completion pulse from memory
//
// Configuration
//   DCACHE_STATS_EN     when defined, adds hit_cnt_o / miss_cnt_o counters.

module dcache_controller #(
  parameter int LINES = 16,
  parameter int IDX_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int TAG_W = 32 - IDX_W - 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITEBACK,
    S_GAP,
    S_FETCH,
    S_REFILL
  } state_t;

  state_t             r_state;
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [255:0]       r_data [LINES];
  logic [IDX_W-1:0]   r_reqIdx;
  logic [TAG_W-1:0]   r_reqTag;
  logic               r_memEnable;
  logic               r_memWrite;
  logic [31:0]        r_memAddr;
  logic [255:0]       r_memData;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic               w_req;
  logic               w_idle;
  logic               w_hit;
  logic               w_miss;
  logic               w_storeHit;
  logic               w_loadHit;
  logic               w_victimDirty;
  logic [255:0]       w_line;
  logic               w_unused;

  // Address decode and hit detection. A store takes priority over a load
  // when both request lines are high, so the load path is masked by MemWrite.
  assign w_idx         = p1_addr_i[IDX_W+4:5];
  assign w_tag         = p1_addr_i[31:IDX_W+5];
  assign w_word        = p1_addr_i[4:2];
  assign w_req         = p1_MemRead_i | p1_MemWrite_i;
  assign w_idle        = (r_state == S_IDLE);
  assign w_hit         = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss        = w_idle & w_req & ~w_hit;
  assign w_storeHit    = w_idle & p1_MemWrite_i & w_hit;
  assign w_loadHit     = w_idle & p1_MemRead_i & ~p1_MemWrite_i & w_hit;
  assign w_victimDirty = r_valid[w_idx] & r_dirty[w_idx];
  assign w_line        = r_data[w_idx];
  assign w_unused      = &{1'b0, p1_addr_i[1:0]};

  // CPU-side outputs are combinational so a hit costs no stall cycle.
  assign p1_data_o  = w_loadHit ? w_line[{w_word, 5'b00000} +: 32] : 32'd0;
  assign p1_stall_o = ~w_idle | w_miss;

  assign mem_enable_o = r_memEnable;
  assign mem_write_o  = r_memWrite;
  assign mem_addr_o   = r_memAddr;
  assign mem_data_o   = r_memData;

  // Miss-handling FSM with registered memory-side outputs. The miss index
  // and tag are latched on entry so the transaction never depends on the
  // address bus during the stall. GAP drops enable for one cycle between a
  // write-back and the following fetch so the memory sees a fresh request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_reqIdx    <= '0;
      r_reqTag    <= '0;
      r_memEnable <= 1'b0;
      r_memWrite  <= 1'b0;
      r_memAddr   <= 32'd0;
      r_memData   <= 256'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_storeHit) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (w_miss) begin
            r_reqIdx    <= w_idx;
            r_reqTag    <= w_tag;
            r_memEnable <= 1'b1;
            if (w_victimDirty) begin
              r_memWrite <= 1'b1;
              r_memAddr  <= {r_tag[w_idx], w_idx, 5'b00000};
              r_memData  <= w_line;
              r_state    <= S_WRITEBACK;
            end else begin
              r_memWrite <= 1'b0;
              r_memAddr  <= {w_tag, w_idx, 5'b00000};
              r_state    <= S_FETCH;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            r_memEnable <= 1'b0;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          r_memEnable <= 1'b1;
          r_memWrite  <= 1'b0;
          r_memAddr   <= {r_reqTag, r_reqIdx, 5'b00000};
          r_state     <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack_i) begin
            r_memEnable <= 1'b0;
            r_state     <= S_REFILL;
          end
        end
        S_REFILL: begin
          r_valid[r_reqIdx] <= 1'b1;
          r_dirty[r_reqIdx] <= 1'b0;
          r_state           <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Line data and tags carry no reset: they are meaningless until the valid
  // bit is set. Refill replaces the whole line; a store hit merges one word.
  always_ff @(posedge clk_i) begin
    if (r_state == S_REFILL) begin
      r_data[r_reqIdx] <= mem_data_i;
      r_tag[r_reqIdx]  <= r_reqTag;
    end else if (w_storeHit) begin
      r_data[w_idx][{w_word, 5'b00000} +: 32] <= p1_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hitCnt;
  logic [31:0] r_missCnt;
  logic        r_postRefill;

  assign hit_cnt_o  = r_hitCnt;
  assign miss_cnt_o = r_missCnt;

  // Statistics. r_postRefill marks the first IDLE cycle after a refill so
  // the re-hit of the request that missed is not counted a second time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hitCnt     <= 32'd0;
      r_missCnt    <= 32'd0;
      r_postRefill <= 1'b0;
    end else begin
      if (r_state == S_REFILL) begin
        r_postRefill <= 1'b1;
      end else if (w_idle) begin
        r_postRefill <= 1'b0;
      end
      if (w_idle & w_hit & ~r_postRefill) begin
        r_hitCnt <= r_hitCnt + 32'd1;
      end
      if (w_miss) begin
        r_missCnt <= r_missCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  localparam int MEM_LAT = 8;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } tx_t;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  int checkCount = 0;
  int errorCount = 0;
  bit cmpEn = 0;

  // Memory image, CPU-visible truth, and the cache tag model
  logic [255:0] backMem [64];
  logic [31:0]  truth   [512];
  bit           mValid  [16];
  bit           mDirty  [16];
  logic [22:0]  mTag    [16];

  // Responder bookkeeping
  tx_t          txLog[$];
  int           memCnt = 0;
  bit           afterAck = 0;
  bit           txUnstable = 0;
  logic [255:0] readData = '0;
  logic [31:0]  lastWbAddr = '0;
  logic [255:0] lastWbData = '0;
  logic [31:0]  lastFetchAddr = '0;

  dcache_controller dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
`endif
  );

  // Free-running clock, period 10
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: every check bumps the counters here
  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Build the line the CPU should see at a line address from the truth words
  function automatic logic [255:0] truthLine(input logic [31:0] a);
    logic [255:0] line;
    logic [8:0]   wi;
    line = '0;
    for (int w = 0; w < 8; w++) begin
      wi = {a[10:5], 3'(w)};
      line[w*32 +: 32] = truth[wi];
    end
    return line;
  endfunction

  // Memory and model reset: the environment resets memory with the cache
  task automatic modelReset();
    for (int l = 0; l < 64; l++)
      for (int w = 0; w < 8; w++)
        backMem[l][w*32 +: 32] = 32'hC0DE0000 + 32'(l * 32 + w * 4);
    for (int i = 0; i < 512; i++)
      truth[i] = 32'hC0DE0000 + 32'(i * 4);
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0;
      mDirty[i] = 0;
      mTag[i]   = '0;
    end
    txLog.delete();
  endtask

  task automatic resetDut();
    rst_i = 1'b1;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    p1_addr_i = '0;
    p1_data_i = '0;
    repeat (2) @(posedge clk_i);
    modelReset();
    #1 rst_i = 1'b0;
  endtask

  // Memory responder: ack in the MEM_LAT-th enabled cycle, data one cycle later
  always @(negedge clk_i) begin
    if (rst_i) begin
      memCnt = 0;
      mem_ack_i = 1'b0;
      afterAck = 0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      afterAck = 1;
      memCnt = 0;
      mem_data_i = readData;
    end else begin
      afterAck = 0;
      if (mem_enable_o) begin
        if (memCnt == 0) begin
          txLog.push_back('{wr: mem_write_o, addr: mem_addr_o, data: mem_data_o});
          if (mem_write_o) begin
            lastWbAddr = mem_addr_o;
            lastWbData = mem_data_o;
          end else begin
            lastFetchAddr = mem_addr_o;
          end
        end else if (txLog.size() > 0) begin
          if (mem_write_o != txLog[txLog.size()-1].wr || mem_addr_o != txLog[txLog.size()-1].addr ||
              (mem_write_o && mem_data_o != txLog[txLog.size()-1].data))
            txUnstable = 1;
        end
        memCnt++;
        if (memCnt == MEM_LAT) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) backMem[mem_addr_o[10:5]] = mem_data_o;
          else readData = backMem[mem_addr_o[10:5]];
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the clock edge
  always @(negedge clk_i) begin
    #2;
    if (!rst_i && cmpEn) begin
      if (afterAck)
        checkOutput("enableAfterAck", {255'd0, mem_enable_o}, 256'd0);
      if (p1_MemRead_i && !p1_MemWrite_i && !p1_stall_o)
        checkOutput("loadData", {224'd0, p1_data_o}, {224'd0, truth[p1_addr_i[10:2]]});
      if (!p1_MemRead_i && !p1_MemWrite_i)
        checkOutput("idleStall", {255'd0, p1_stall_o}, 256'd0);
    end
  end

  // One CPU access; the model predicts stall length and memory traffic
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data,
                               output int stallCnt, output logic [31:0] loadData);
    logic [3:0]  idx;
    logic [22:0] tag;
    bit          hit;
    bit          dirtyVictim;
    int          expStall;
    int          expTx;
    int          n;
    logic [31:0] victimAddr;
    logic [31:0] fetchAddr;
    idx = addr[8:5];
    tag = addr[31:9];
    hit = mValid[idx] && (mTag[idx] == tag);
    dirtyVictim = !hit && mValid[idx] && mDirty[idx];
    expStall = hit ? 0 : (dirtyVictim ? 2 * MEM_LAT + 3 : MEM_LAT + 2);
    expTx = hit ? 0 : (dirtyVictim ? 2 : 1);
    victimAddr = {mTag[idx], idx, 5'b00000};
    fetchAddr = {tag, idx, 5'b00000};
    txLog.delete();
    txUnstable = 0;
    p1_addr_i = addr;
    p1_data_i = data;
    p1_MemWrite_i = isWrite;
    p1_MemRead_i = !isWrite;
    stallCnt = 0;
    n = 0;
    @(negedge clk_i);
    while (p1_stall_o && n < 200) begin
      stallCnt++;
      n++;
      @(negedge clk_i);
    end
    loadData = p1_data_o;
    checkOutput("stallCycles", 256'(stallCnt), 256'(expStall));
    checkOutput("txCount", 256'(txLog.size()), 256'(expTx));
    checkOutput("txStable", {255'd0, txUnstable}, 256'd0);
    if (dirtyVictim && txLog.size() == 2) begin
      checkOutput("wbWrite", {255'd0, txLog[0].wr}, 256'd1);
      checkOutput("wbAddr", {224'd0, txLog[0].addr}, {224'd0, victimAddr});
      checkOutput("wbData", txLog[0].data, truthLine(victimAddr));
      checkOutput("fetchWrite", {255'd0, txLog[1].wr}, 256'd0);
      checkOutput("fetchAddr", {224'd0, txLog[1].addr}, {224'd0, fetchAddr});
    end else if (!hit && txLog.size() == 1) begin
      checkOutput("fetchWrite", {255'd0, txLog[0].wr}, 256'd0);
      checkOutput("fetchAddr", {224'd0, txLog[0].addr}, {224'd0, fetchAddr});
    end
    @(posedge clk_i);
    #1;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    if (!hit) begin
      mValid[idx] = 1;
      mTag[idx] = tag;
      mDirty[idx] = 0;
    end
    if (isWrite) begin
      mDirty[idx] = 1;
      truth[addr[10:2]] = data;
    end
  endtask

  initial begin
    int          stallCnt;
    logic [31:0] loadData;
    int          n;
    rst_i = 1'b1;
    p1_addr_i = '0;
    p1_data_i = '0;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    resetDut();
    cmpEn = 1;

    $display("[TB] reset values");
    checkOutput("rstStall", {255'd0, p1_stall_o}, 256'd0);
    checkOutput("rstEnable", {255'd0, mem_enable_o}, 256'd0);
    checkOutput("rstWrite", {255'd0, mem_write_o}, 256'd0);
    checkOutput("rstAddr", {224'd0, mem_addr_o}, 256'd0);
    checkOutput("rstMemData", mem_data_o, 256'd0);
    checkOutput("rstData", {224'd0, p1_data_o}, 256'd0);

    $display("[TB] case 1: clean miss");
    applyStimulus(0, 32'h0000_0040, 32'd0, stallCnt, loadData);
    checkOutput("c1Stall", 256'(stallCnt), 256'd10);
    checkOutput("c1Data", {224'd0, loadData}, {224'd0, 32'hC0DE0040});
    checkOutput("c1FetchAddr", {224'd0, lastFetchAddr}, {224'd0, 32'h40});

    $display("[TB] case 2: hit in refilled line");
    applyStimulus(0, 32'h0000_0044, 32'd0, stallCnt, loadData);
    checkOutput("c2Stall", 256'(stallCnt), 256'd0);
    checkOutput("c2Data", {224'd0, loadData}, {224'd0, 32'hC0DE0044});

    $display("[TB] case 3: store hit then load");
    applyStimulus(1, 32'h0000_0048, 32'hDEADBEEF, stallCnt, loadData);
    checkOutput("c3StoreStall", 256'(stallCnt), 256'd0);
    applyStimulus(0, 32'h0000_0048, 32'd0, stallCnt, loadData);
    checkOutput("c3Data", {224'd0, loadData}, {224'd0, 32'hDEADBEEF});

    $display("[TB] case 4: dirty miss");
    applyStimulus(0, 32'h0000_0248, 32'd0, stallCnt, loadData);
    checkOutput("c4Stall", 256'(stallCnt), 256'd19);
    checkOutput("c4WbAddr", {224'd0, lastWbAddr}, {224'd0, 32'h40});
    checkOutput("c4WbWord2", {224'd0, lastWbData[95:64]}, {224'd0, 32'hDEADBEEF});
    checkOutput("c4FetchAddr", {224'd0, lastFetchAddr}, {224'd0, 32'h240});
    checkOutput("c4Data", {224'd0, loadData}, {224'd0, 32'hC0DE0248});
`ifdef DCACHE_STATS_EN
    checkOutput("hitCnt", {224'd0, hit_cnt_o}, 256'd3);
    checkOutput("missCnt", {224'd0, miss_cnt_o}, 256'd2);
`endif

    $display("[TB] dirty miss back to the first tag");
    applyStimulus(1, 32'h0000_024C, 32'h12345678, stallCnt, loadData);
    applyStimulus(0, 32'h0000_004C, 32'd0, stallCnt, loadData);
    checkOutput("xStall", 256'(stallCnt), 256'd19);
    checkOutput("xWbWord3", {224'd0, lastWbData[127:96]}, {224'd0, 32'h12345678});
    checkOutput("xData", {224'd0, loadData}, {224'd0, 32'hC0DE004C});

    $display("[TB] case 5: reset during fetch");
    applyStimulus(1, 32'h0000_0044, 32'hA5A5A5A5, stallCnt, loadData);
    p1_addr_i = 32'h0000_0244;
    p1_MemWrite_i = 1'b0;
    p1_MemRead_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!(mem_enable_o && !mem_write_o) && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    checkOutput("c5FetchReached", {255'd0, (n < 100)}, 256'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    p1_MemRead_i = 1'b0;
    #1;
    checkOutput("c5Enable", {255'd0, mem_enable_o}, 256'd0);
    checkOutput("c5Stall", {255'd0, p1_stall_o}, 256'd0);
    checkOutput("c5Write", {255'd0, mem_write_o}, 256'd0);
    repeat (2) @(posedge clk_i);
    modelReset();
    #1 rst_i = 1'b0;
    applyStimulus(0, 32'h0000_0044, 32'd0, stallCnt, loadData);
    checkOutput("c5MissStall", 256'(stallCnt), 256'd10);
    checkOutput("c5Data", {224'd0, loadData}, {224'd0, 32'hC0DE0044});

    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
